alu_op_driver: RTL and testbench

// - Initiator for the registered 8-op ALU mux (opcodes 0..7, 33-bit result, 1-clk latency).
// - Accepts op requests on a valid/ready port and drives the ALU operands/select.
// - Captures the ALU result and returns it with its tag on a valid/ready response port.
// - Holds the ALU in its synchronous reset while this block is in reset.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/sat_counter.sv | 31 +++
 rtl/alu_op_driver.sv | 124 ++++++++++++
 tb/tb_alu_op_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operand driver.
//   op_e        - ALU opcodes as decoded by the registered 8-op ALU mux.
//   drv_state_e - driver FSM states; one op in flight at a time.
//   ALU_LAT     - ALU result latency in clocks (registered mux).
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_SUB  = 3'd1,
      OP_ADD  = 3'd2,
      OP_SQA  = 3'd3,
      OP_SQB  = 3'd4,
      OP_MSKA = 3'd5,
      OP_ZERO = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } drv_state_e;

   localparam int ALU_LAT = 1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset, clears the count
//   inc   - increment by one (ignored once saturated)
//   clear - synchronous clear, has priority over inc
//   count - current value
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator for the registered 8-op ALU mux.
// Takes one op request at a time, drives the ALU operands/select, captures
// the 1-clk-latency ALU result and returns it with its tag on a response
// port. Opcode 7 is illegal: its response carries rsp_err=1 and data 0.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/ready          - request handshake
//   req_op, req_a, req_b     - opcode and operands
//   req_tag                  - tag echoed on the response
//   alu_rst                  - sync active-high reset to the ALU
//   alu_sel, alu_a..alu_d    - ALU select and operands (c/d tied to 0)
//   alu_out                  - ALU registered result (DATA_W+1 bits)
//   rsp_valid/ready          - response handshake
//   rsp_data, rsp_tag, rsp_err - result, tag, illegal-op flag
//   op_count, err_count      - saturating completed-op / error counters
module alu_op_driver
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              alu_rst,
   output logic [2:0]        alu_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_c,
   output logic [DATA_W-1:0] alu_d,
   input  logic [DATA_W:0]   alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  err_count
);

   drv_state_e       state;
   logic [TAG_W-1:0] tag_p0;
   logic             err_p0;
   logic             done;

   assign alu_c = '0;
   assign alu_d = '0;

   // alu_rst is a registered flag so the ALU sees its reset on the first
   // edge after release; requests are held off until it has dropped.
   assign req_ready = (state == IDLE) && !alu_rst;
   assign done      = (state == RESP) && rsp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         alu_rst   <= 1'b1;
         alu_sel   <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         tag_p0    <= '0;
         err_p0    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         alu_rst <= 1'b0;
         case (state)
            // request capture
            IDLE: begin
               if (req_valid && req_ready) begin
                  alu_sel <= req_op;
                  alu_a   <= req_a;
                  alu_b   <= req_b;
                  tag_p0  <= req_tag;
                  err_p0  <= (req_op == OP_ILL);
                  state   <= ISSUE;
               end
            end
            // ALU samples its operands on this edge
            ISSUE: state <= WAIT;
            // ALU result stable; illegal-op result is discarded
            WAIT: begin
               rsp_data  <= err_p0 ? '0 : alu_out;
               rsp_tag   <= tag_p0;
               rsp_err   <= err_p0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            // response held until accepted
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_op_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (done),
      .clear (1'b0),
      .count (op_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (done && rsp_err),
      .clear (1'b0),
      .count (err_count)
   );

endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed bench for alu_op_driver with a behavioural
// registered ALU. Counters are built 3 bits wide so saturation is reached.
module tb_alu_op_driver;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;
   localparam int CNT_W  = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [DATA_W-1:0] req_a, req_b;
   logic [TAG_W-1:0]  req_tag;
   logic              alu_rst;
   logic [2:0]        alu_sel;
   logic [DATA_W-1:0] alu_a, alu_b, alu_c, alu_d;
   logic [DATA_W:0]   alu_out;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W:0]   rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_err;
   logic [CNT_W-1:0]  op_count, err_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_ops  = 0;
   int exp_errs = 0;

   always #5 clk = ~clk;

   alu_op_driver #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .alu_rst   (alu_rst),
      .alu_sel   (alu_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c     (alu_c),
      .alu_d     (alu_d),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err),
      .op_count  (op_count),
      .err_count (err_count)
   );

   // Behavioural registered ALU; op 7 yields garbage the driver must drop.
   function automatic logic [DATA_W:0] sq(input logic [DATA_W-1:0] x);
      logic [2*DATA_W-1:0] t;
      t = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, x};
      return t[DATA_W:0];
   endfunction

   always_ff @(posedge clk) begin
      if (alu_rst)
         alu_out <= '0;
      else begin
         case (alu_sel)
            3'd0: alu_out <= {1'b0, alu_a & alu_b};
            3'd1: alu_out <= {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_out <= {1'b0, alu_a} + {1'b0, alu_b};
            3'd3: alu_out <= sq(alu_a);
            3'd4: alu_out <= sq(alu_b);
            3'd5: alu_out <= {1'b0, alu_a & 32'h0000_FFFF};
            3'd6: alu_out <= '0;
            default: alu_out <= 33'h1_DEAD_BEEF;
         endcase
      end
   end

   typedef struct {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W:0]   exp;
      logic              exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic bump(input logic is_err);
      if (exp_ops != int'(CNT_MAX)) exp_ops++;
      if (is_err && exp_errs != int'(CNT_MAX)) exp_errs++;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic do_vec(input vec_t v);
      int k;
      wait_ready();
      req_op = v.op; req_a = v.a; req_b = v.b; req_tag = v.tag;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("busy_ready", {63'd0, req_ready}, 64'd0);
      k = 0;
      while (k < 8) begin
         @(posedge clk); #1;
         k++;
         if (rsp_valid) break;
      end
      chk("latency", 64'(k), 64'd2);
      chk("rsp_data", 64'(rsp_data), 64'(v.exp));
      chk("rsp_tag", 64'(rsp_tag), 64'(v.tag));
      chk("rsp_err", {63'd0, rsp_err}, {63'd0, v.exp_err});
      @(posedge clk); #1;
      bump(v.exp_err);
      chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
      chk("op_count", 64'(op_count), 64'(exp_ops));
      chk("err_count", 64'(err_count), 64'(exp_errs));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{3'd2, 32'd5,          32'd7,          4'd3,  33'd12,           1'b0};
      vecs[1] = '{3'd1, 32'd0,          32'd1,          4'd1,  33'h1_FFFF_FFFF,  1'b0};
      vecs[2] = '{3'd3, 32'hFFFF_FFFF,  32'd0,          4'd2,  33'h0_0000_0001,  1'b0};
      vecs[3] = '{3'd7, 32'd1,          32'd2,          4'd9,  33'd0,            1'b1};
      vecs[4] = '{3'd0, 32'hFF00_FF00,  32'h0F0F_0F0F,  4'd4,  33'h0_0F00_0F00,  1'b0};
      vecs[5] = '{3'd4, 32'd0,          32'h0001_0000,  4'd5,  33'h1_0000_0000,  1'b0};
      vecs[6] = '{3'd6, 32'h1234_5678,  32'h9ABC_DEF0,  4'd6,  33'd0,            1'b0};
      vecs[7] = '{3'd7, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd15, 33'd0,            1'b1};
      vecs[8] = '{3'd5, 32'h1234_5678,  32'd0,          4'd7,  33'h0_0000_5678,  1'b0};
      vecs[9] = '{3'd2, 32'hFFFF_FFFF,  32'd1,          4'd8,  33'h1_0000_0000,  1'b0};

      rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      req_tag = '0; rsp_ready = 1'b1;

      // Reset state and alu_rst release
      repeat (3) @(negedge clk);
      chk("rst_alu_rst", {63'd0, alu_rst}, 64'd1);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_tag, rsp_data}, 64'd0);
      chk("rst_alu_ops", {alu_sel, alu_a, alu_b[28:0]}, 64'd0);
      chk("rst_counts", {58'd0, op_count, err_count}, 64'd0);
      chk("alu_cd_zero", {alu_c, alu_d}, 64'd0);
      rst = 1'b1;
      #1;
      chk("rel_alu_rst_held", {62'd0, alu_rst, req_ready}, 64'd2);
      @(posedge clk); #1;
      chk("rel_alu_rst_drop", {62'd0, alu_rst, req_ready}, 64'd1);

      // Table-driven ops, including counter saturation at 7
      for (int i = 0; i < 10; i++) do_vec(vecs[i]);

      // Backpressure with a second request held pending
      wait_ready();
      rsp_ready = 1'b0;
      req_op = 3'd2; req_a = 32'd100; req_b = 32'd23; req_tag = 4'd5;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 3'd4; req_a = 32'd0; req_b = 32'd3; req_tag = 4'd6;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_first", {29'd0, rsp_valid, rsp_err, rsp_tag, rsp_data}, {29'd0, 1'b1, 1'b0, 4'd5, 33'd123});
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_hold", {28'd0, req_ready, rsp_valid, rsp_err, rsp_tag, rsp_data},
             {28'd0, 1'b0, 1'b1, 1'b0, 4'd5, 33'd123});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      bump(1'b0);
      chk("bp_handshake", {62'd0, rsp_valid, req_ready}, 64'd1);
      chk("bp_op_count", 64'(op_count), 64'(exp_ops));
      @(posedge clk); #1;
      chk("bp_second_accept", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_second", {29'd0, rsp_valid, rsp_err, rsp_tag, rsp_data}, {29'd0, 1'b1, 1'b0, 4'd6, 33'd9});
      @(posedge clk); #1;
      bump(1'b0);
      chk("bp_second_done", {62'd0, rsp_valid, req_ready}, 64'd1);

      // Reset while the op is in WAIT
      wait_ready();
      req_op = 3'd2; req_a = 32'd1; req_b = 32'd1; req_tag = 4'd2;
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      exp_ops = 0; exp_errs = 0;
      chk("mid_rst_state", {60'd0, alu_rst, rsp_valid, req_ready, 1'b0}, 64'd8);
      chk("mid_rst_counts", {58'd0, op_count, err_count}, 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_no_rsp_rel", {62'd0, rsp_valid, alu_rst}, 64'd0);
      do_vec(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
